seven_segment_decoder: RTL

//  Receive side of the 7-segment interface: samples a 7-bit segment bus, waits until the pattern is stable,

---
 rtl/seven_segment_pkg.sv | 31 +++
 rtl/seg_pattern_lookup.sv | 42 ++++
 rtl/seven_segment_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the 7-segment receive path.
// Segment bus ordering: bit6=a ... bit0=g, 1 = segment lit.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_SETTLE   = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_CHG = 2'd2
    } dec_state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational reverse lookup: segment pattern -> digit, legal flag, blank flag.
// This is the only decode table in the design. Defining SEG_DECODE_HEX_EN
// adds the hex glyphs A..F (10..15); otherwise those glyphs are illegal.
module seg_pattern_lookup
    import seven_segment_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] digit,
    output logic       legal,
    output logic       is_blank
);

    // Map one pattern to its digit; anything not in the table stays illegal.
    always_comb begin
        digit    = 4'd0;
        legal    = 1'b0;
        is_blank = 1'b0;
        case (seg)
            SEG_0:     begin digit = 4'd0;  legal = 1'b1; end
            SEG_1:     begin digit = 4'd1;  legal = 1'b1; end
            SEG_2:     begin digit = 4'd2;  legal = 1'b1; end
            SEG_3:     begin digit = 4'd3;  legal = 1'b1; end
            SEG_4:     begin digit = 4'd4;  legal = 1'b1; end
            SEG_5:     begin digit = 4'd5;  legal = 1'b1; end
            SEG_6:     begin digit = 4'd6;  legal = 1'b1; end
            SEG_7:     begin digit = 4'd7;  legal = 1'b1; end
            SEG_8:     begin digit = 4'd8;  legal = 1'b1; end
            SEG_9:     begin digit = 4'd9;  legal = 1'b1; end
`ifdef SEG_DECODE_HEX_EN
            SEG_A:     begin digit = 4'd10; legal = 1'b1; end
            SEG_B:     begin digit = 4'd11; legal = 1'b1; end
            SEG_C:     begin digit = 4'd12; legal = 1'b1; end
            SEG_D:     begin digit = 4'd13; legal = 1'b1; end
            SEG_E:     begin digit = 4'd14; legal = 1'b1; end
            SEG_F:     begin digit = 4'd15; legal = 1'b1; end
`endif
            SEG_BLANK: begin is_blank = 1'b1; end
            default:   begin legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// 7-segment receive decoder: debounces the segment bus, decodes a stable
// pattern once, and offers the digit on a valid/ready handshake. Illegal
// stable patterns pulse pattern_err and bump a saturating counter.
// Optional feature macro: SEG_DECODE_HEX_EN (hex glyphs A..F decode to 10..15).
module seven_segment_decoder
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    output logic [3:0]           digit_out,
    output logic                 digit_valid,
    input  logic                 digit_ready,
    output logic                 pattern_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 blank
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    seg_t                 seg_q_r;
    logic [CNT_W-1:0]     cnt_r;
    dec_state_e           state_r,   state_s;
    seg_t                 latched_r, latched_s;
    logic [3:0]           digit_r,   digit_s;
    logic                 valid_r,   valid_s;
    logic                 err_r,     err_s;
    logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic                 blank_r,   blank_s;

    logic [3:0]           lk_digit_s;
    logic                 lk_legal_s;
    logic                 lk_blank_s;
    logic                 stable_s;

    // The decode always looks at the sampled bus, never the raw input.
    seg_pattern_lookup u_lookup (
        .seg      (seg_q_r),
        .digit    (lk_digit_s),
        .legal    (lk_legal_s),
        .is_blank (lk_blank_s)
    );

    assign stable_s = (cnt_r == CNT_MAX);

    // Sample the bus and count consecutive equal samples, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q_r <= SEG_BLANK;
            cnt_r   <= '0;
        end else begin
            seg_q_r <= seg_in;
            if (seg_in != seg_q_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state and next-output logic; pattern_err is a single-cycle pulse.
    always_comb begin
        state_s   = state_r;
        latched_s = latched_r;
        digit_s   = digit_r;
        valid_s   = valid_r;
        err_s     = 1'b0;
        err_cnt_s = err_cnt_r;
        blank_s   = blank_r;
        case (state_r)
            ST_SETTLE: begin
                if (stable_s) begin
                    latched_s = seg_q_r;
                    if (lk_legal_s) begin
                        digit_s = lk_digit_s;
                        valid_s = 1'b1;
                        state_s = ST_HOLD;
                    end else if (lk_blank_s) begin
                        blank_s = 1'b1;
                        state_s = ST_WAIT_CHG;
                    end else begin
                        err_s = 1'b1;
                        if (err_cnt_r != ERR_MAX) begin
                            err_cnt_s = err_cnt_r + ERR_CNT_W'(1'b1);
                        end else begin
                            err_cnt_s = err_cnt_r;
                        end
                        state_s = ST_WAIT_CHG;
                    end
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                // Digit stays frozen until the consumer takes it; if the bus
                // has already moved on, start settling the new pattern.
                if (valid_r && digit_ready) begin
                    valid_s = 1'b0;
                    if (seg_q_r == latched_r) begin
                        state_s = ST_WAIT_CHG;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_WAIT_CHG: begin
                if (seg_q_r != latched_r) begin
                    blank_s = 1'b0;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_WAIT_CHG;
                end
            end
            default: begin
                valid_s = 1'b0;
                blank_s = 1'b0;
                state_s = ST_SETTLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_SETTLE;
            latched_r <= SEG_BLANK;
            digit_r   <= 4'd0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
            blank_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            latched_r <= latched_s;
            digit_r   <= digit_s;
            valid_r   <= valid_s;
            err_r     <= err_s;
            err_cnt_r <= err_cnt_s;
            blank_r   <= blank_s;
        end
    end

    assign digit_out   = digit_r;
    assign digit_valid = valid_r;
    assign pattern_err = err_r;
    assign err_count   = err_cnt_r;
    assign blank       = blank_r;

endmodule
